// File: rtl/itch_msg_tx_if.sv
// Message-in / beat-out bundle for itch_msg_tx: parallel message handshake plus
// the moldudp64 payload beat stream. The DUT uses the slave modport.
interface itch_msg_tx_if #(
  parameter int AXI_DATA_W = 64,
  parameter int AXI_KEEP_W = AXI_DATA_W/8,
  parameter int LEN_W      = 16,
  parameter int MAX_W      = 8*AXI_DATA_W
);
  logic                  msg_v_i;
  logic [LEN_W-1:0]      msg_len_i;
  logic [MAX_W-1:0]      msg_data_i;
  logic                  msg_ready_o;
  logic                  msg_err_o;
  logic                  mold_v_o;
  logic                  mold_ready_i;
  logic                  mold_start_o;
  logic                  mold_last_o;
  logic [AXI_DATA_W-1:0] mold_data_o;
  logic [AXI_KEEP_W-1:0] mold_keep_o;

  modport master (
    output msg_v_i, msg_len_i, msg_data_i, mold_ready_i,
    input  msg_ready_o, msg_err_o, mold_v_o, mold_start_o, mold_last_o,
           mold_data_o, mold_keep_o
  );

  modport slave (
    input  msg_v_i, msg_len_i, msg_data_i, mold_ready_i,
    output msg_ready_o, msg_err_o, mold_v_o, mold_start_o, mold_last_o,
           mold_data_o, mold_keep_o
  );
endinterface

// File: rtl/itch_msg_tx.sv
// Serialises one parallel ITCH message into 64-bit moldudp64 payload beats.
// Define ITCH_TX_LEN_PREFIX_EN to prepend the 2-byte big-endian length field.
module itch_msg_tx #(
  parameter int AXI_DATA_W    = 64,
  parameter int AXI_KEEP_W    = AXI_DATA_W/8,
  parameter int MSG_MAX_BYTES = 50,
  parameter int CNT_MAX       = 8,
  parameter int CNT_MAX_W     = $clog2(CNT_MAX)+1,
  parameter int LEN_W         = 16,
  parameter int MAX_W         = CNT_MAX*AXI_DATA_W
) (
  input  logic         clk,
  input  logic         nreset,
  itch_msg_tx_if.slave bus
);
  localparam int LANE_IDX_W = $clog2(AXI_KEEP_W);
  localparam int BEAT_IDX_W = $clog2(CNT_MAX);
`ifdef ITCH_TX_LEN_PREFIX_EN
  localparam int PREFIX_BYTES = 2;
`else
  localparam int PREFIX_BYTES = 0;
`endif

  typedef logic [CNT_MAX-1:0][AXI_DATA_W-1:0] beat_arr_t;
  typedef enum logic {IDLE, SEND} state_e;

  state_e                state_q;
  beat_arr_t             buf_q;
  logic [CNT_MAX_W-1:0]  cnt_q, nbeats_q;
  logic [AXI_KEEP_W-1:0] last_keep_q;
  logic                  ready_q, err_q, v_q, start_q, last_q;
  logic [AXI_DATA_W-1:0] data_q;
  logic [AXI_KEEP_W-1:0] keep_q;

  beat_arr_t             stream_d;
  logic [LEN_W-1:0]      total_d;
  logic [CNT_MAX_W-1:0]  nbeats_d, cnt_d;
  logic [AXI_KEEP_W-1:0] tail_keep_d, first_keep_d, next_keep_d;
  logic [AXI_DATA_W-1:0] first_data_d, next_data_d;
  logic                  len_ok_d, accept_d, beat_done_d, first_last_d, next_last_d;

  // Keep mask for the final beat: remainder bytes, or a full beat if none.
  function automatic logic [AXI_KEEP_W-1:0] tail_keep(input logic [LEN_W-1:0] total);
    logic [LANE_IDX_W-1:0] rem;
    rem = total[LANE_IDX_W-1:0];
    if (rem == '0) return '1;
    return (AXI_KEEP_W'(1) << rem) - AXI_KEEP_W'(1);
  endfunction

  function automatic logic [AXI_DATA_W-1:0] mask_lanes(input logic [AXI_DATA_W-1:0] w,
                                                       input logic [AXI_KEEP_W-1:0] k);
    logic [AXI_DATA_W-1:0] r;
    r = '0;
    for (int b = 0; b < AXI_KEEP_W; b++) r[8*b +: 8] = k[b] ? w[8*b +: 8] : 8'h00;
    return r;
  endfunction

`ifdef ITCH_TX_LEN_PREFIX_EN
  logic unused_msg_hi;
  assign unused_msg_hi = ^bus.msg_data_i[MAX_W-1 -: 16];
`endif

  always_comb begin
    // NOTE: every always_comb output is assigned before any branch so no latch can form.
`ifdef ITCH_TX_LEN_PREFIX_EN
    stream_d = beat_arr_t'({bus.msg_data_i[MAX_W-17:0], bus.msg_len_i[7:0], bus.msg_len_i[15:8]});
`else
    stream_d = beat_arr_t'(bus.msg_data_i);
`endif
    total_d      = bus.msg_len_i + LEN_W'(PREFIX_BYTES);
    nbeats_d     = CNT_MAX_W'((total_d + LEN_W'(AXI_KEEP_W-1)) >> LANE_IDX_W);
    len_ok_d     = (bus.msg_len_i != '0) && (bus.msg_len_i <= LEN_W'(MSG_MAX_BYTES));
    accept_d     = bus.msg_v_i & ready_q;
    tail_keep_d  = tail_keep(total_d);
    first_last_d = (nbeats_d == CNT_MAX_W'(1));
    first_keep_d = first_last_d ? tail_keep_d : '1;
    first_data_d = mask_lanes(stream_d[0], first_keep_d);
    cnt_d        = cnt_q + CNT_MAX_W'(1);
    next_last_d  = (cnt_d == nbeats_q - CNT_MAX_W'(1));
    next_keep_d  = next_last_d ? last_keep_q : '1;
    next_data_d  = mask_lanes(buf_q[cnt_d[BEAT_IDX_W-1:0]], next_keep_d);
    beat_done_d  = v_q & bus.mold_ready_i;
  end

  // NOTE: the payload buffer carries no reset; it is only read after a load.
  always_ff @(posedge clk) begin
    if (state_q == IDLE && accept_d && len_ok_d) buf_q <= stream_d;
  end

  always_ff @(posedge clk) begin
    if (nreset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      nbeats_q    <= '0;
      last_keep_q <= '0;
      ready_q     <= 1'b1;
      err_q       <= 1'b0;
      v_q         <= 1'b0;
      start_q     <= 1'b0;
      last_q      <= 1'b0;
      data_q      <= '0;
      keep_q      <= '0;
    end else begin
      err_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (accept_d) begin
            if (len_ok_d) begin
              state_q     <= SEND;
              ready_q     <= 1'b0;
              cnt_q       <= '0;
              nbeats_q    <= nbeats_d;
              last_keep_q <= tail_keep_d;
              v_q         <= 1'b1;
              start_q     <= 1'b1;
              last_q      <= first_last_d;
              data_q      <= first_data_d;
              keep_q      <= first_keep_d;
            end else begin
              err_q <= 1'b1;
            end
          end
        end
        SEND: begin
          // Beat fields only move on a completed handshake, so stalls hold them.
          if (beat_done_d) begin
            if (last_q) begin
              state_q <= IDLE;
              ready_q <= 1'b1;
              cnt_q   <= '0;
              v_q     <= 1'b0;
              start_q <= 1'b0;
              last_q  <= 1'b0;
              data_q  <= '0;
              keep_q  <= '0;
            end else begin
              cnt_q   <= cnt_d;
              start_q <= 1'b0;
              last_q  <= next_last_d;
              data_q  <= next_data_d;
              keep_q  <= next_keep_d;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.msg_ready_o  = ready_q;
  assign bus.msg_err_o    = err_q;
  assign bus.mold_v_o     = v_q;
  assign bus.mold_start_o = start_q;
  assign bus.mold_last_o  = last_q;
  assign bus.mold_data_o  = data_q;
  assign bus.mold_keep_o  = keep_q;
endmodule

// File: tb/tb_itch_msg_tx.sv
// Self-checking bench for itch_msg_tx: table-driven messages, a byte-level
// reference model feeding a beat scoreboard, and hand-written reset sequences.
module tb_itch_msg_tx;
  localparam int MAX_W = 512;

  logic clk = 1'b0;
  logic nreset;
  always #5 clk = ~clk;

  itch_msg_tx_if bus ();
  itch_msg_tx dut (.clk(clk), .nreset(nreset), .bus(bus));

  typedef struct {
    logic [63:0] data;
    logic [7:0]  keep;
    logic        start;
    logic        last;
  } beat_t;

  typedef struct {
    int         len;
    int         stall;
    logic [7:0] seed;
    bit         exp_err;
    int         exp_nb;
    logic [7:0] exp_keep;
  } vec_t;

  beat_t sb[$];
  beat_t held, exp_beat;
  logic  held_v = 1'b0;
  int    checks = 0;
  int    errors = 0;
  int    popped = 0;
  vec_t  vecs[8];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference model: build the byte stream, then cut it into 8-byte beats.
  task automatic push_model(input int len, input logic [MAX_W-1:0] msg);
    byte unsigned s[$];
    beat_t b;
    int total, nb, pos;
    s = {};
`ifdef ITCH_TX_LEN_PREFIX_EN
    s.push_back(8'(len >> 8));
    s.push_back(8'(len));
`endif
    for (int k = 0; k < len; k++) s.push_back(msg[8*k +: 8]);
    total = s.size();
    nb = (total + 7) / 8;
    for (int i = 0; i < nb; i++) begin
      b.data = '0;
      b.keep = '0;
      for (int l = 0; l < 8; l++) begin
        pos = 8*i + l;
        if (pos < total) begin
          b.data[8*l +: 8] = s[pos];
          b.keep[l] = 1'b1;
        end
      end
      b.start = (i == 0);
      b.last  = (i == nb - 1);
      sb.push_back(b);
    end
  endtask

  // Beat monitor: hold-stability under stall and scoreboard compare on handshake.
  always @(negedge clk) begin
    if (bus.mold_v_o === 1'b1) begin
      if (held_v) begin
        check("hold_data", bus.mold_data_o, held.data);
        check("hold_keep", bus.mold_keep_o, held.keep);
        check("hold_start", bus.mold_start_o, held.start);
        check("hold_last", bus.mold_last_o, held.last);
      end
      if (bus.mold_ready_i === 1'b1) begin
        held_v = 1'b0;
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_beat: got data 0x%0h, expected no beat", bus.mold_data_o);
        end else begin
          exp_beat = sb.pop_front();
          check("beat_data", bus.mold_data_o, exp_beat.data);
          check("beat_keep", bus.mold_keep_o, exp_beat.keep);
          check("beat_start", bus.mold_start_o, exp_beat.start);
          check("beat_last", bus.mold_last_o, exp_beat.last);
          popped++;
        end
      end else begin
        held_v     = 1'b1;
        held.data  = bus.mold_data_o;
        held.keep  = bus.mold_keep_o;
        held.start = bus.mold_start_o;
        held.last  = bus.mold_last_o;
      end
    end else begin
      held_v = 1'b0;
    end
  end

  function automatic logic [MAX_W-1:0] make_msg(input logic [7:0] seed);
    logic [MAX_W-1:0] m;
    for (int k = 0; k < MAX_W/8; k++) m[8*k +: 8] = seed + 8'(k);
    return m;
  endfunction

  task automatic run_msg(input string tag, input int len, input int stall, input logic [7:0] seed,
                         input bit exp_err, input int exp_nb, input logic [7:0] exp_keep,
                         input bit chk0, input logic [63:0] exp0);
    logic [MAX_W-1:0] msg;
    int t;
    msg = make_msg(seed);
    t = 0;
    while (bus.msg_ready_o !== 1'b1 && t < 100) begin
      @(posedge clk); #1;
      t++;
    end
    check({tag, "_ready_in"}, bus.msg_ready_o, 1);
    if (!exp_err) push_model(len, msg);
    popped = 0;
    bus.msg_v_i      = 1'b1;
    bus.msg_len_i    = 16'(len);
    bus.msg_data_i   = msg;
    bus.mold_ready_i = 1'b0;
    @(posedge clk); #1;
    // Junk offered while busy must be ignored.
    bus.msg_v_i    = !exp_err;
    bus.msg_len_i  = 16'd8;
    bus.msg_data_i = ~msg;
    check({tag, "_err"}, bus.msg_err_o, exp_err);
    check({tag, "_v_first"}, bus.mold_v_o, !exp_err);
    check({tag, "_ready_busy"}, bus.msg_ready_o, exp_err);
    if (chk0) check({tag, "_data0"}, bus.mold_data_o, exp0);
    if (exp_err) begin
      bus.msg_v_i = 1'b0;
      @(posedge clk); #1;
      check({tag, "_err_pulse"}, bus.msg_err_o, 0);
      check({tag, "_v_idle"}, bus.mold_v_o, 0);
      check({tag, "_ready_idle"}, bus.msg_ready_o, 1);
    end else begin
      for (int b = 0; b < exp_nb; b++) begin
        repeat (stall) begin
          @(posedge clk); #1;
        end
        if (b == exp_nb - 1) begin
          check({tag, "_last_flag"}, bus.mold_last_o, 1);
          check({tag, "_last_keep"}, bus.mold_keep_o, exp_keep);
        end
        bus.mold_ready_i = 1'b1;
        @(posedge clk); #1;
        bus.mold_ready_i = 1'b0;
      end
      bus.msg_v_i = 1'b0;
      check({tag, "_v_done"}, bus.mold_v_o, 0);
      check({tag, "_ready_back"}, bus.msg_ready_o, 1);
      check({tag, "_beats"}, 64'(popped), 64'(exp_nb));
      check({tag, "_sb_empty"}, 64'(sb.size()), 0);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [MAX_W-1:0] msg;
    int nb8;
    logic [7:0] k8;
`ifdef ITCH_TX_LEN_PREFIX_EN
    vecs[0] = '{8,  0, 8'h01, 1'b0, 2, 8'h03};
    vecs[1] = '{50, 0, 8'h10, 1'b0, 7, 8'h0F};
    vecs[2] = '{20, 3, 8'h40, 1'b0, 3, 8'h3F};
    vecs[3] = '{0,  0, 8'h00, 1'b1, 0, 8'h00};
    vecs[4] = '{51, 0, 8'h00, 1'b1, 0, 8'h00};
    vecs[5] = '{1,  1, 8'h7E, 1'b0, 1, 8'h07};
    vecs[6] = '{9,  2, 8'h90, 1'b0, 2, 8'h07};
    vecs[7] = '{16, 0, 8'hC0, 1'b0, 3, 8'h03};
    nb8 = 2;
    k8  = 8'h03;
`else
    vecs[0] = '{8,  0, 8'h01, 1'b0, 1, 8'hFF};
    vecs[1] = '{50, 0, 8'h10, 1'b0, 7, 8'h03};
    vecs[2] = '{20, 3, 8'h40, 1'b0, 3, 8'h0F};
    vecs[3] = '{0,  0, 8'h00, 1'b1, 0, 8'h00};
    vecs[4] = '{51, 0, 8'h00, 1'b1, 0, 8'h00};
    vecs[5] = '{1,  1, 8'h7E, 1'b0, 1, 8'h01};
    vecs[6] = '{9,  2, 8'h90, 1'b0, 2, 8'h01};
    vecs[7] = '{16, 0, 8'hC0, 1'b0, 2, 8'hFF};
    nb8 = 1;
    k8  = 8'hFF;
`endif
    nreset           = 1'b1;
    bus.msg_v_i      = 1'b0;
    bus.msg_len_i    = '0;
    bus.msg_data_i   = '0;
    bus.mold_ready_i = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    nreset = 1'b0;
    check("rst_ready", bus.msg_ready_o, 1);
    check("rst_err", bus.msg_err_o, 0);
    check("rst_v", bus.mold_v_o, 0);
    check("rst_start", bus.mold_start_o, 0);
    check("rst_last", bus.mold_last_o, 0);
    check("rst_data", bus.mold_data_o, 0);
    check("rst_keep", bus.mold_keep_o, 0);

`ifdef ITCH_TX_LEN_PREFIX_EN
    run_msg("pfx_len6", 6, 0, 8'hA0, 1'b0, 1, 8'hFF, 1'b1, 64'hA5A4A3A2A1A0_0600);
`else
    run_msg("len8", 8, 0, 8'h01, 1'b0, 1, 8'hFF, 1'b1, 64'h0807060504030201);
`endif

    foreach (vecs[i])
      run_msg($sformatf("vec%0d", i), vecs[i].len, vecs[i].stall, vecs[i].seed,
              vecs[i].exp_err, vecs[i].exp_nb, vecs[i].exp_keep, 1'b0, 64'h0);

    // Reset while beat 1 of a 24-byte message is stalled.
    msg = make_msg(8'h30);
    push_model(24, msg);
    bus.msg_v_i    = 1'b1;
    bus.msg_len_i  = 16'd24;
    bus.msg_data_i = msg;
    @(posedge clk); #1;
    bus.msg_v_i      = 1'b0;
    bus.mold_ready_i = 1'b1;
    @(posedge clk); #1;
    bus.mold_ready_i = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("midrst_v_before", bus.mold_v_o, 1);
    check("midrst_start_before", bus.mold_start_o, 0);
    nreset = 1'b1;
    @(posedge clk); #1;
    nreset = 1'b0;
    check("midrst_v", bus.mold_v_o, 0);
    check("midrst_ready", bus.msg_ready_o, 1);
    check("midrst_last", bus.mold_last_o, 0);
    check("midrst_keep", bus.mold_keep_o, 0);
    sb.delete();
    run_msg("post_rst", 8, 0, 8'h55, 1'b0, nb8, k8, 1'b0, 64'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
